pingpong16: RTL and testbench

Two-entry ping-pong buffer that accepts 16-bit words over a valid/ready handshake and holds them in two slot registers. It presents both slots and a select line directly to the downstream 16-bit 2:1 word mux, which forms the output word. The block owns all storage, ordering and flow control; the mux is purely combinational.

---
 rtl/pingpong16_pkg.sv | 9 +
 rtl/pp_slot.sv | 20 ++
 rtl/pingpong16.sv | 93 +++++++++
 tb/tb_pingpong16.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pingpong16_pkg.sv
// rtl/pingpong16_pkg.sv - shared width and types for the pingpong16 buffer
package pingpong16_pkg;

    localparam int W = 16;

    typedef logic [W-1:0] word_t;
    typedef logic         slot_t;

endpackage

// File: rtl/pp_slot.sv
// rtl/pp_slot.sv - one W-bit storage slot with load enable
module pp_slot
    import pingpong16_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  ld,
    input  word_t d,
    output word_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pingpong16.sv
// rtl/pingpong16.sv - two-entry ping-pong buffer feeding an external 2:1 word mux
module pingpong16
    import pingpong16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  word_t      in_data,
    output word_t      buf0,
    output word_t      buf1,
    output logic       sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] count
);

    logic  v0, v1;
    slot_t wp, rp;
    logic  v0_n, v1_n;
    slot_t wp_n, rp_n;
    logic  wr_fire, rd_fire;
    logic  ld0, ld1;

    // Handshake flags come only from registered state, never from in_valid/out_ready.
    assign in_ready  = wp ? !v1 : !v0;
    assign out_valid = rp ? v1 : v0;
    assign sel       = rp;
    assign count     = {1'b0, v0} + {1'b0, v1};

    // Flush wins over any concurrent transfer, so it also blocks the slot load.
    assign wr_fire = in_valid && in_ready && !flush;
    assign rd_fire = out_valid && out_ready && !flush;
    assign ld0     = wr_fire && (wp == 1'b0);
    assign ld1     = wr_fire && (wp == 1'b1);

    always_comb begin
        v0_n = v0;
        v1_n = v1;
        wp_n = wp;
        rp_n = rp;
        if (flush) begin
            v0_n = 1'b0;
            v1_n = 1'b0;
            wp_n = 1'b0;
            rp_n = 1'b0;
        end else begin
            // A simultaneous read and write always hit different slots, so order is irrelevant.
            if (rd_fire) begin
                if (rp == 1'b0) v0_n = 1'b0;
                else            v1_n = 1'b0;
                rp_n = !rp;
            end
            if (wr_fire) begin
                if (wp == 1'b0) v0_n = 1'b1;
                else            v1_n = 1'b1;
                wp_n = !wp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            wp <= 1'b0;
            rp <= 1'b0;
        end else begin
            v0 <= v0_n;
            v1 <= v1_n;
            wp <= wp_n;
            rp <= rp_n;
        end
    end

    pp_slot u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld0),
        .d     (in_data),
        .q     (buf0)
    );

    pp_slot u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld1),
        .d     (in_data),
        .q     (buf1)
    );

endmodule

// File: tb/tb_pingpong16.sv
// tb/tb_pingpong16.sv - directed self-checking bench for pingpong16
module tb_pingpong16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] buf0;
    logic [15:0] buf1;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;
    logic [15:0] mux_word;

    int n_checks = 0;
    int n_pass   = 0;

    pingpong16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .buf0      (buf0),
        .buf1      (buf1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    // Stand-in for the downstream 2:1 word mux.
    assign mux_word = sel ? buf1 : buf0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready",  {15'd0, in_ready},  16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_sel",       {15'd0, sel},       16'd0);
        check("rst_count",     {14'd0, count},     16'd0);
        check("rst_buf0",      buf0,               16'h0000);
        check("rst_buf1",      buf1,               16'h0000);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        // Fill
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        check("fill1_buf0",      buf0,               16'h1234);
        check("fill1_count",     {14'd0, count},     16'd1);
        check("fill1_out_valid", {15'd0, out_valid}, 16'd1);
        check("fill1_in_ready",  {15'd0, in_ready},  16'd1);
        in_data = 16'hABCD;
        step();
        check("fill2_buf1",     buf1,              16'hABCD);
        check("fill2_count",    {14'd0, count},    16'd2);
        check("fill2_in_ready", {15'd0, in_ready}, 16'd0);
        in_data = 16'h5555;
        step();
        check("full_count", {14'd0, count}, 16'd2);
        check("full_buf0",  buf0,           16'h1234);
        check("full_buf1",  buf1,           16'hABCD);
        in_valid = 1'b0;

        // Drain order
        out_ready = 1'b1;
        check("drain0_sel",  {15'd0, sel}, 16'd0);
        check("drain0_word", mux_word,     16'h1234);
        step();
        check("drain1_sel",   {15'd0, sel},       16'd1);
        check("drain1_word",  mux_word,           16'hABCD);
        check("drain1_valid", {15'd0, out_valid}, 16'd1);
        check("drain1_count", {14'd0, count},     16'd1);
        step();
        check("drain2_valid",    {15'd0, out_valid}, 16'd0);
        check("drain2_count",    {14'd0, count},     16'd0);
        check("drain2_in_ready", {15'd0, in_ready},  16'd1);

        // Streaming: word k is presented after edge k, sel alternates from 0
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = 16'(k);
            step();
            check($sformatf("stream%0d_word", k),  mux_word,           16'(k));
            check($sformatf("stream%0d_sel", k),   {15'd0, sel},       16'((k - 1) % 2));
            check($sformatf("stream%0d_count", k), {14'd0, count},     16'd1);
            check($sformatf("stream%0d_valid", k), {15'd0, out_valid}, 16'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_count", {14'd0, count}, 16'd0);

        // Flush from full with concurrent write and read
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1111;
        step();
        in_data = 16'h2222;
        step();
        check("preflush_count", {14'd0, count}, 16'd2);
        flush     = 1'b1;
        in_data   = 16'h7777;
        out_ready = 1'b1;
        step();
        check("flush_count",     {14'd0, count},     16'd0);
        check("flush_sel",       {15'd0, sel},       16'd0);
        check("flush_in_ready",  {15'd0, in_ready},  16'd1);
        check("flush_out_valid", {15'd0, out_valid}, 16'd0);
        check("flush_buf0",      buf0,               16'h1111);
        check("flush_buf1",      buf1,               16'h2222);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Async reset mid-stream with count=1 and wp pointing at slot 1
        in_valid = 1'b1;
        in_data  = 16'h4444;
        step();
        in_valid = 1'b0;
        check("prereset_count", {14'd0, count}, 16'd1);
        check("prereset_buf0",  buf0,           16'h4444);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",     {14'd0, count},     16'd0);
        check("arst_out_valid", {15'd0, out_valid}, 16'd0);
        check("arst_in_ready",  {15'd0, in_ready},  16'd1);
        check("arst_sel",       {15'd0, sel},       16'd0);
        check("arst_buf0",      buf0,               16'h0000);
        check("arst_buf1",      buf1,               16'h0000);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h9999;
        step();
        in_valid = 1'b0;
        check("post_rst_buf0",  buf0,           16'h9999);
        check("post_rst_buf1",  buf1,           16'h0000);
        check("post_rst_count", {14'd0, count}, 16'd1);
        check("post_rst_word",  mux_word,       16'h9999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
